move_scheduler: RTL and testbench
=================================

# move_scheduler

Sequences all motion of the active tetromino. Collects left/right button requests and the gravity tick, arbitrates them onto the three registered collision checkers (left, right, down), waits out the checker's one-cycle latency, and commits the new XPOS/YPOS or signals a piece lock. It sits between the input/timing logic and the board-update logic and is the only writer of the piece position.

## Interface
- `SPAWN_X`, default 4: XPOS loaded on spawn.
- `MAX_Y`, default 16: largest legal YPOS (piece rows YPOS..YPOS+3 ≤ 19).
- `REPEAT_CYCLES`, default 12_500_000: held-button repeat period; used only with `MOVE_SCHED_AUTOREPEAT_EN`.
- `Clock` input, 1 bit: the single clock.
- `Resetn` input, 1 bit: synchronous, active-low reset.
- `leftBtn`, `rightBtn` input, 1 bit each: synchronized button levels.
- `dropTick` input, 1 bit: one-cycle gravity pulse.
- `newPiece` input, 1 bit: one-cycle pulse to spawn the next piece.
- `canL`, `canR`, `canD` input, 1 bit each: registered checker results, valid the cycle after their enable.
- `enL`, `enR`, `enD` output, 1 bit each: checker enables, one-hot or all-zero.
- `XPOS` output, 4 bits: piece column.
- `YPOS` output, 5 bits: piece row.
- `lockPiece` output, 1 bit: one-cycle pulse when a down move fails.
- `pieceActive` output, 1 bit: high from spawn until lock.
- `busy` output, 1 bit: high in ISSUE and EVAL.

## Operation
- States: WAIT_SPAWN, IDLE, ISSUE, EVAL.
- WAIT_SPAWN:
  - On `newPiece`: XPOS←SPAWN_X, YPOS←0, pending bits cleared, go to IDLE.
  - All other requests are ignored.
- Request capture, in any state other than WAIT_SPAWN:
  - A rising edge of `leftBtn` sets pendL; a rising edge of `rightBtn` sets pendR; `dropTick` sets pendD.
  - A request that arrives while its bit is already set merges into that bit.
  - A bit clears only when its check is issued.
- IDLE: if any pending bit is set, go to ISSUE. The selection is latched with fixed priority pendD > pendL > pendR.
- ISSUE:
  - Drive exactly the selected enable for this one cycle and clear the selected pending bit.
  - Go to EVAL.
- EVAL: sample the selected `can*` result.
  - L: XPOS−1 if canL.
  - R: XPOS+1 if canR.
  - D: YPOS+1 if canD and YPOS<MAX_Y. Otherwise pulse `lockPiece`, drop `pieceActive`, clear all pending bits, go to WAIT_SPAWN.
  - In every case that does not lock, go to IDLE.
- Left and right edges in the same cycle: both are latched; L is served first, then R (net zero displacement).
- `newPiece` outside WAIT_SPAWN is ignored.
- XPOS and YPOS never change except in EVAL or on spawn. Wrap-around is impossible because the checkers bound XPOS and the controller bounds YPOS at MAX_Y.

## Timing
- Reset (`Resetn`=0 at a rising edge), from any state including mid-check:
  - State←WAIT_SPAWN, pending←0, XPOS←SPAWN_X, YPOS←0.
  - `enL`/`enR`/`enD`=0, `lockPiece`=0, `pieceActive`=0, `busy`=0.
- Latency, with E0 the edge at which the request sets its pending bit:
  - E1: IDLE→ISSUE.
  - E2: the checker samples its enable.
  - E3: XPOS/YPOS update (or `lockPiece` asserts for the cycle after E3).
  - Minimum spacing between committed moves: 3 cycles.
- The enables are high for exactly one cycle per check and are decoded from state ISSUE.
- `lockPiece` is registered: high for the single cycle after the failing EVAL.

## Configuration
- `MOVE_SCHED_AUTOREPEAT_EN` defined:
  - While `leftBtn` (or `rightBtn`) stays high, a per-button counter re-sets pendL (or pendR) every REPEAT_CYCLES cycles after the initial edge.
  - The counter restarts on button release and on spawn.
- Undefined: edge-only requests. The counter logic and `REPEAT_CYCLES` are unused.

## Structure
- Shared package `tetris_pkg` holds:
  - The state enum: WAIT_SPAWN, IDLE, ISSUE, EVAL.
  - The move-select enum: MV_L, MV_R, MV_D.
  - The constants SPAWN_X and MAX_Y, shared with the checkers.
- One sub-module, `move_req_latch`: edge detection, the pending bits, clear-on-issue, and the optional autorepeat counters. The FSM and position registers stay in `move_scheduler`.

## Test plan
- Reset then a `newPiece` pulse → XPOS=4, YPOS=0, `pieceActive`=1, all enables 0.
- `leftBtn` edge with canL=1 → `enL` high for exactly one cycle; XPOS goes 4→3 three edges after capture.
- `rightBtn` edge with canR=0 → `enR` pulses once; XPOS stays 4; state returns to IDLE.
- `dropTick` plus both button edges in the same cycle, all can*=1 → enables fire in the order D, L, R; final XPOS=4, YPOS=1.
- `dropTick` with canD=0 at YPOS=7, a left edge pending → `lockPiece` pulses once, pendL is discarded, state WAIT_SPAWN, XPOS/YPOS hold 4/7.
- `Resetn` low during EVAL of a right move → no XPOS change, state WAIT_SPAWN.
- With the macro defined, `leftBtn` held for 2×REPEAT_CYCLES+1 cycles → 3 left moves.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared tetromino-motion types and board constants used by the scheduler and the collision checkers.
// Pure declarations: no latency, no flow control.
package tetris_pkg;

    typedef enum logic [1:0] {
        WAIT_SPAWN = 2'd0,
        IDLE       = 2'd1,
        ISSUE      = 2'd2,
        EVAL       = 2'd3
    } sched_state_t;

    // Values double as bit positions in the pending-request vector.
    typedef enum logic [1:0] {
        MV_L = 2'd0,
        MV_R = 2'd1,
        MV_D = 2'd2
    } move_sel_t;

    localparam int SPAWN_X       = 4;
    localparam int MAX_Y         = 16;
    localparam int REPEAT_CYCLES = 12_500_000;

    // Gravity beats player input; left beats right.
    function automatic move_sel_t pick_move(input logic [2:0] pend);
        if (pend[MV_D])      return MV_D;
        else if (pend[MV_L]) return MV_L;
        else                 return MV_R;
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Request/checker/position bundle between input logic, collision checkers and the move scheduler.
// master = surrounding logic, slave = scheduler.
interface move_scheduler_if;
    logic       leftBtn;
    logic       rightBtn;
    logic       dropTick;
    logic       newPiece;
    logic       canL;
    logic       canR;
    logic       canD;
    logic       enL;
    logic       enR;
    logic       enD;
    logic [3:0] XPOS;
    logic [4:0] YPOS;
    logic       lockPiece;
    logic       pieceActive;
    logic       busy;

    modport master (
        output leftBtn, rightBtn, dropTick, newPiece, canL, canR, canD,
        input  enL, enR, enD, XPOS, YPOS, lockPiece, pieceActive, busy
    );

    modport slave (
        input  leftBtn, rightBtn, dropTick, newPiece, canL, canR, canD,
        output enL, enR, enD, XPOS, YPOS, lockPiece, pieceActive, busy
    );
endinterface

// File: rtl/move_scheduler_req.sv
// move_req_latch: button edge detect and sticky pending bits {D,R,L}; optional held-button repeat (MOVE_SCHED_AUTOREPEAT_EN).
// Bits set one cycle after the request; a new request beats a same-cycle clear, clr_all beats everything.
module move_req_latch #(
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       leftBtn,
    input  logic       rightBtn,
    input  logic       dropTick,
    input  logic       capture,
    input  logic       clr_all,
    input  logic [2:0] clr_sel,
    output logic [2:0] pend
);

    logic       left_q;
    logic       right_q;
    logic       rep_l;
    logic       rep_r;
    logic [2:0] set_req;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            left_q  <= leftBtn;
            right_q <= rightBtn;
        end
    end

`ifdef MOVE_SCHED_AUTOREPEAT_EN
    localparam int CW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] cnt_l;
    logic [CW-1:0] cnt_r;

    // Counters run only while the button has been high for more than one cycle.
    always_ff @(posedge Clock) begin
        if (!Resetn || clr_all || !leftBtn || !left_q || cnt_l == LAST) cnt_l <= '0;
        else                                                            cnt_l <= cnt_l + 1'b1;
        if (!Resetn || clr_all || !rightBtn || !right_q || cnt_r == LAST) cnt_r <= '0;
        else                                                              cnt_r <= cnt_r + 1'b1;
    end

    assign rep_l = leftBtn  & left_q  & (cnt_l == LAST);
    assign rep_r = rightBtn & right_q & (cnt_r == LAST);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_CYCLES;
    assign rep_l = 1'b0;
    assign rep_r = 1'b0;
`endif

    assign set_req = {dropTick,
                      (rightBtn & ~right_q) | rep_r,
                      (leftBtn  & ~left_q)  | rep_l};

    always_ff @(posedge Clock) begin
        if (!Resetn || clr_all) pend <= 3'b000;
        else                    pend <= (pend & ~clr_sel) | (capture ? set_req : 3'b000);
    end

endmodule

// File: rtl/move_scheduler.sv
// Tetromino motion sequencer: arbitrates L/R/gravity onto the collision checkers and owns XPOS/YPOS; request-to-commit 3 cycles.
// No backpressure: requests merge into pending bits; optional held-button repeat under MOVE_SCHED_AUTOREPEAT_EN.
module move_scheduler #(
    parameter int SPAWN_X       = tetris_pkg::SPAWN_X,
    parameter int MAX_Y         = tetris_pkg::MAX_Y,
    parameter int REPEAT_CYCLES = tetris_pkg::REPEAT_CYCLES
) (
    input  logic             Clock,
    input  logic             Resetn,
    move_scheduler_if.slave  bus
);
    import tetris_pkg::*;

    localparam logic [3:0] X_SPAWN = 4'(SPAWN_X);
    localparam logic [4:0] Y_LAST  = 5'(MAX_Y);

    sched_state_t state;
    sched_state_t state_nxt;
    move_sel_t    sel;
    logic [2:0]   pend;
    logic [2:0]   clr_sel;
    logic         clr_all;
    logic         down_ok;
    logic [3:0]   xpos;
    logic [4:0]   ypos;
    logic         lock_q;
    logic         active_q;

    assign down_ok = bus.canD && (ypos < Y_LAST);

    move_req_latch #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_req (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .leftBtn  (bus.leftBtn),
        .rightBtn (bus.rightBtn),
        .dropTick (bus.dropTick),
        .capture  (state != WAIT_SPAWN),
        .clr_all  (clr_all),
        .clr_sel  (clr_sel),
        .pend     (pend)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) state <= WAIT_SPAWN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_sel   = 3'b000;
        clr_all   = 1'b0;
        case (state)
            WAIT_SPAWN: if (bus.newPiece) begin
                state_nxt = IDLE;
                clr_all   = 1'b1;
            end
            IDLE:       if (|pend) state_nxt = ISSUE;
            ISSUE: begin
                state_nxt    = EVAL;
                clr_sel[sel] = 1'b1;
            end
            EVAL: begin
                state_nxt = IDLE;
                if (sel == MV_D && !down_ok) begin
                    state_nxt = WAIT_SPAWN;
                    clr_all   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            xpos     <= X_SPAWN;
            ypos     <= 5'd0;
            sel      <= MV_L;
            lock_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            lock_q <= 1'b0;
            case (state)
                WAIT_SPAWN: if (bus.newPiece) begin
                    xpos     <= X_SPAWN;
                    ypos     <= 5'd0;
                    active_q <= 1'b1;
                end
                IDLE: sel <= pick_move(pend);
                EVAL: case (sel)
                    MV_L: if (bus.canL) xpos <= xpos - 4'd1;
                    MV_R: if (bus.canR) xpos <= xpos + 4'd1;
                    MV_D: if (down_ok) ypos <= ypos + 5'd1;
                          else begin
                              lock_q   <= 1'b1;
                              active_q <= 1'b0;
                          end
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

    assign bus.enL         = (state == ISSUE) && (sel == MV_L);
    assign bus.enR         = (state == ISSUE) && (sel == MV_R);
    assign bus.enD         = (state == ISSUE) && (sel == MV_D);
    assign bus.XPOS        = xpos;
    assign bus.YPOS        = ypos;
    assign bus.lockPiece   = lock_q;
    assign bus.pieceActive = active_q;
    assign bus.busy        = (state == ISSUE) || (state == EVAL);

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: per-cycle comparison against a request/phase model plus literal spot checks.
module tb_move_scheduler;

    logic Clock = 1'b0;
    logic Resetn;
    always #5 Clock = ~Clock;

    move_scheduler_if bus ();

    move_scheduler dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Model: piece alive flag, position, pending set, and how far into a check we are
    // (0 = none, 1 = enable cycle, 2 = result cycle).
    bit  model_on = 1'b0;
    bit  m_active, m_lock, locked, prev_l, prev_r, sl, sr, sd;
    bit  m_pend [3];
    int  m_x, m_y, m_phase, m_cur;
    int  en_log [$];

    always @(posedge Clock) begin
        if (!Resetn) begin
            m_active = 0; m_lock = 0; m_x = 4; m_y = 0; m_phase = 0; m_cur = 0;
            m_pend   = '{0, 0, 0};
            prev_l   = 0; prev_r = 0;
        end else begin
            sl = bus.leftBtn && !prev_l;
            sr = bus.rightBtn && !prev_r;
            sd = bus.dropTick;
            locked = 0;
            m_lock = 0;
            if (!m_active) begin
                if (bus.newPiece) begin
                    m_active = 1; m_x = 4; m_y = 0; m_pend = '{0, 0, 0};
                end
            end else begin
                if (m_phase == 0) begin
                    if (m_pend[2])      begin m_cur = 2; m_phase = 1; end
                    else if (m_pend[0]) begin m_cur = 0; m_phase = 1; end
                    else if (m_pend[1]) begin m_cur = 1; m_phase = 1; end
                end else if (m_phase == 1) begin
                    m_pend[m_cur] = 0;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                    if (m_cur == 0 && bus.canL) m_x = m_x - 1;
                    if (m_cur == 1 && bus.canR) m_x = m_x + 1;
                    if (m_cur == 2) begin
                        if (bus.canD && m_y < 16) m_y = m_y + 1;
                        else begin
                            locked = 1; m_lock = 1; m_active = 0; m_pend = '{0, 0, 0};
                        end
                    end
                end
                if (!locked) begin
                    if (sl) m_pend[0] = 1;
                    if (sr) m_pend[1] = 1;
                    if (sd) m_pend[2] = 1;
                end
            end
            prev_l = bus.leftBtn;
            prev_r = bus.rightBtn;
        end
    end

    logic [14:0] exp_v, act_v;
    always @(negedge Clock) begin
        if (model_on) begin
            exp_v = {m_phase == 1 && m_cur == 0, m_phase == 1 && m_cur == 1, m_phase == 1 && m_cur == 2,
                     m_lock, m_active, m_phase != 0, 4'(m_x), 5'(m_y)};
            act_v = {bus.enL, bus.enR, bus.enD, bus.lockPiece, bus.pieceActive, bus.busy, bus.XPOS, bus.YPOS};
            check("cycle{enL,enR,enD,lock,active,busy,X,Y}", int'(act_v), int'(exp_v));
            if (bus.enL) en_log.push_back(0);
            if (bus.enR) en_log.push_back(1);
            if (bus.enD) en_log.push_back(2);
        end
    end

    task automatic drop_once;
        bus.dropTick = 1; cyc(1); bus.dropTick = 0; cyc(3);
    endtask

    task automatic press(input bit left);
        if (left) bus.leftBtn = 1; else bus.rightBtn = 1;
        cyc(4);
        bus.leftBtn = 0; bus.rightBtn = 0;
        cyc(2);
    endtask

    task automatic spawn;
        bus.newPiece = 1; cyc(1); bus.newPiece = 0;
    endtask

    initial begin
        Resetn = 0;
        bus.leftBtn = 0; bus.rightBtn = 0; bus.dropTick = 0; bus.newPiece = 0;
        bus.canL = 0; bus.canR = 0; bus.canD = 0;
        cyc(2);
        model_on = 1;
        check("reset_xpos", bus.XPOS, 4);
        check("reset_ypos", bus.YPOS, 0);
        check("reset_active", bus.pieceActive, 0);
        check("reset_busy_en_lock", {bus.busy, bus.enL, bus.enR, bus.enD, bus.lockPiece}, 0);
        Resetn = 1;
        cyc(1);

        spawn();
        check("spawn_xy", {bus.XPOS, bus.YPOS}, {4'd4, 5'd0});
        check("spawn_active", bus.pieceActive, 1);

        // Left with canL=1: XPOS must still be 4 after E2 and become 3 at E3.
        bus.canL = 1; bus.canR = 1; bus.canD = 1;
        en_log.delete();
        bus.leftBtn = 1;
        cyc(3);
        check("left_before_e3", bus.XPOS, 4);
        cyc(1);
        check("left_at_e3", bus.XPOS, 3);
        bus.leftBtn = 0;
        cyc(3);
        check("left_enl_count", en_log.size(), 1);
        if (en_log.size() == 1) check("left_enl_which", en_log[0], 0);

        press(0);
        check("right_ok", bus.XPOS, 4);

        // Blocked right move.
        bus.canR = 0;
        en_log.delete();
        press(0);
        check("right_blocked_x", bus.XPOS, 4);
        check("right_blocked_enr", en_log.size(), 1);
        check("right_blocked_idle", {bus.busy, bus.pieceActive}, 2'b01);

        // Drop, left and right together: served D, L, R.
        bus.canR = 1;
        en_log.delete();
        bus.dropTick = 1; bus.leftBtn = 1; bus.rightBtn = 1;
        cyc(1);
        bus.dropTick = 0;
        cyc(12);
        bus.leftBtn = 0; bus.rightBtn = 0;
        check("combo_count", en_log.size(), 3);
        if (en_log.size() == 3) check("combo_order", en_log[0] * 100 + en_log[1] * 10 + en_log[2], 201);
        check("combo_xy", {bus.XPOS, bus.YPOS}, {4'd4, 5'd1});

        repeat (6) drop_once();
        check("fall_to_7", bus.YPOS, 7);

        // Failing drop with a left request pending: lock, left discarded.
        bus.canD = 0;
        en_log.delete();
        bus.dropTick = 1; bus.leftBtn = 1;
        cyc(1);
        bus.dropTick = 0;
        cyc(3);
        check("lock_pulse_high", bus.lockPiece, 1);
        cyc(1);
        check("lock_pulse_low", bus.lockPiece, 0);
        check("lock_inactive", bus.pieceActive, 0);
        bus.leftBtn = 0;
        cyc(6);
        check("lock_only_end", en_log.size(), 1);
        check("lock_hold_xy", {bus.XPOS, bus.YPOS}, {4'd4, 5'd7});

        // Requests while waiting for a spawn are ignored.
        bus.dropTick = 1; bus.leftBtn = 1;
        cyc(1);
        bus.dropTick = 0; bus.leftBtn = 0;
        cyc(4);
        check("wait_ignore", {bus.busy, bus.XPOS, bus.YPOS}, {1'b0, 4'd4, 5'd7});

        // Floor: canD=1 still locks once YPOS reaches MAX_Y.
        bus.canD = 1;
        spawn();
        check("respawn_y", bus.YPOS, 0);
        repeat (16) drop_once();
        check("floor_y", bus.YPOS, 16);
        bus.dropTick = 1; cyc(1); bus.dropTick = 0; cyc(3);
        check("floor_lock", {bus.lockPiece, bus.pieceActive, bus.YPOS}, {1'b1, 1'b0, 5'd16});
        cyc(2);

        // newPiece while a piece is active is ignored.
        spawn();
        press(1);
        spawn();
        cyc(2);
        check("newpiece_ignored", bus.XPOS, 3);
        press(1);
        check("second_left", bus.XPOS, 2);

        // Reset during the result cycle of a right move.
        bus.rightBtn = 1;
        cyc(3);
        check("mid_eval_busy", bus.busy, 1);
        Resetn = 0;
        cyc(1);
        Resetn = 1; bus.rightBtn = 0;
        check("reset_mid_eval", {bus.XPOS, bus.pieceActive, bus.busy}, {4'd4, 1'b0, 1'b0});
        drop_once();
        check("after_reset_wait", {bus.busy, bus.YPOS}, {1'b0, 5'd0});

        model_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
